// File: rtl/val2_pkg.sv
// Shared types for the Val2 shift sequencer: FSM states, shift-type encodings, amount width.
package val2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Encodings match instruction bits [6:5]
    localparam logic [1:0] LSL = 2'd0;
    localparam logic [1:0] LSR = 2'd1;
    localparam logic [1:0] ASR = 2'd2;
    localparam logic [1:0] ROR = 2'd3;

    localparam int AMT_W = 5;

endpackage

// File: rtl/val2_shift_sequencer_if.sv
// Request/response bundle between the ID/EXE stage and the Val2 shift sequencer.
interface val2_shift_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] rm_val;
    logic [11:0] shifter_operand;
    logic        imm;
    logic        mem_en;
    logic        carry_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] val2;
    logic        carry_out;

    modport master (
        output req_valid, rm_val, shifter_operand, imm, mem_en, carry_in, rsp_ready,
        input  req_ready, rsp_valid, val2, carry_out
    );

    modport slave (
        input  req_valid, rm_val, shifter_operand, imm, mem_en, carry_in, rsp_ready,
        output req_ready, rsp_valid, val2, carry_out
    );
endinterface

// File: rtl/val2_shift_step.sv
// One partial shift/rotate of a 32-bit value by 0..STEP bits, with the last bit shifted out.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module val2_shift_step
    import val2_pkg::*;
(
    input  logic [31:0]      din,
    input  logic [AMT_W-1:0] amt,
    input  logic [1:0]       sh_type,
    input  logic             cin,
    output logic [31:0]      dout,
    output logic             cout
);

    logic [32:0] wide;
    logic [5:0]  ror_back;

    always_comb begin
        wide     = 33'd0;
        ror_back = 6'd32 - {1'b0, amt};
        dout     = din;
        cout     = cin;
        // The 33rd bit of the widened value holds the last bit to leave the word
        unique case (sh_type)
            LSL: begin
                wide = {1'b0, din} << amt;
                dout = wide[31:0];
                cout = (amt == '0) ? cin : wide[32];
            end
            LSR: begin
                wide = {din, 1'b0} >> amt;
                dout = wide[32:1];
                cout = (amt == '0) ? cin : wide[0];
            end
            ASR: begin
                wide = $unsigned($signed({din, 1'b0}) >>> amt);
                dout = wide[32:1];
                cout = (amt == '0) ? cin : wide[0];
            end
            default: begin
                dout = (din >> amt) | (din << ror_back);
                cout = (amt == '0) ? cin : dout[31];
            end
        endcase
    end

endmodule

// File: rtl/val2_shift_sequencer.sv
// Multi-cycle ARM32 Val2 generator (mem offset / rotated immediate / shifted register); VAL2_CARRY_OUT_EN adds carry out.
// Latency: 1 + ceil(amount/STEP) cycles from acceptance to rsp_valid; 1 cycle for mem_en or zero amount.
// Backpressure: one request in flight; req_ready only in IDLE, result held in DONE until rsp_ready; flush aborts.
module val2_shift_sequencer
    import val2_pkg::*;
#(
    parameter int STEP = 4
)
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    val2_shift_sequencer_if.slave        bus,
    output logic                         busy
);

    state_t           state;
    logic [31:0]      val_q;
    logic [AMT_W-1:0] amt_q;
    logic [1:0]       type_q;
    logic             rsp_valid_q;
    logic             req_ready_q;
    logic             busy_q;

    logic [31:0]      cap_val;
    logic [AMT_W-1:0] cap_amt;
    logic [1:0]       cap_type;
    logic [AMT_W-1:0] step_amt;
    logic [31:0]      step_val;
    logic             step_cout;
    logic             step_cin;

    always_comb begin
        cap_val  = bus.rm_val;
        cap_amt  = bus.shifter_operand[11:7];
        cap_type = bus.shifter_operand[6:5];
        if (bus.mem_en) begin
            cap_val  = {{20{bus.shifter_operand[11]}}, bus.shifter_operand};
            cap_amt  = '0;
            cap_type = LSL;
        end else if (bus.imm) begin
            cap_val  = {24'd0, bus.shifter_operand[7:0]};
            cap_amt  = {bus.shifter_operand[11:8], 1'b0};
            cap_type = ROR;
        end
    end

    assign step_amt = (amt_q > AMT_W'(STEP)) ? AMT_W'(STEP) : amt_q;

    val2_shift_step u_step (
        .din     (val_q),
        .amt     (step_amt),
        .sh_type (type_q),
        .cin     (step_cin),
        .dout    (step_val),
        .cout    (step_cout)
    );

`ifdef VAL2_CARRY_OUT_EN
    logic carry_q;
    assign step_cin      = carry_q;
    assign bus.carry_out = carry_q;
`else
    logic unused_carry;
    assign step_cin      = 1'b0;
    assign bus.carry_out = 1'b0;
    assign unused_carry  = ^{step_cout, bus.carry_in};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            val_q       <= '0;
            amt_q       <= '0;
            type_q      <= LSL;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
`ifdef VAL2_CARRY_OUT_EN
            carry_q     <= 1'b0;
`endif
        end else if (flush) begin
            // Abort wins over acceptance and response handshake; val2 keeps its last value
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        val_q       <= cap_val;
                        amt_q       <= cap_amt;
                        type_q      <= cap_type;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
`ifdef VAL2_CARRY_OUT_EN
                        carry_q     <= bus.carry_in;
`endif
                        if (cap_amt == '0) begin
                            state       <= DONE;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state       <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    val_q <= step_val;
                    amt_q <= amt_q - step_amt;
`ifdef VAL2_CARRY_OUT_EN
                    carry_q <= step_cout;
`endif
                    if (amt_q == step_amt) begin
                        state       <= DONE;
                        rsp_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.val2      = val_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.req_ready = req_ready_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_val2_shift_sequencer.sv
// Directed bench for val2_shift_sequencer (STEP=4): vector table plus stall, flush and reset sequences.
module tb_val2_shift_sequencer;

    logic clk;
    logic rst_n;
    logic flush;
    logic busy;
    int   checks;
    int   failures;

    val2_shift_sequencer_if bus ();

    val2_shift_sequencer #(.STEP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rm_val;
        logic [11:0] op;
        logic        imm;
        logic        mem_en;
        logic        cin;
        logic [31:0] exp_val2;
        logic        exp_carry;
        int          exp_lat;
    } tv_t;

    tv_t tv [10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic exp_c(input logic c);
`ifdef VAL2_CARRY_OUT_EN
        return c;
`else
        return 1'b0 & c;
`endif
    endfunction

    task automatic drive_req(input logic [31:0] rm, input logic [11:0] op,
                             input logic im, input logic me, input logic ci);
        bus.rm_val          = rm;
        bus.shifter_operand = op;
        bus.imm             = im;
        bus.mem_en          = me;
        bus.carry_in        = ci;
        bus.req_valid       = 1'b1;
    endtask

    task automatic scramble();
        bus.req_valid       = 1'b0;
        bus.rm_val          = ~bus.rm_val;
        bus.shifter_operand = ~bus.shifter_operand;
        bus.imm             = ~bus.imm;
        bus.mem_en          = ~bus.mem_en;
        bus.carry_in        = ~bus.carry_in;
    endtask

    task automatic run_vec(input tv_t v);
        int lat;
        @(negedge clk);
        drive_req(v.rm_val, v.op, v.imm, v.mem_en, v.cin);
        @(posedge clk); #1;
        scramble();
        lat = 1;
        while (!bus.rsp_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check({v.name, ".lat"}, lat, v.exp_lat);
        check({v.name, ".val2"}, bus.val2, v.exp_val2);
        check({v.name, ".carry"}, {31'd0, bus.carry_out}, {31'd0, exp_c(v.exp_carry)});
        check({v.name, ".busy"}, {31'd0, busy}, 32'd1);
        check({v.name, ".req_ready_done"}, {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check({v.name, ".rsp_clear"}, {31'd0, bus.rsp_valid}, 32'd0);
        check({v.name, ".req_ready_idle"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        bit seen;
        bit rr_seen;
        int lat;
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        bus.req_valid       = 1'b0;
        bus.rsp_ready       = 1'b0;
        bus.rm_val          = '0;
        bus.shifter_operand = '0;
        bus.imm             = 1'b0;
        bus.mem_en          = 1'b0;
        bus.carry_in        = 1'b0;

        tv[0] = '{"imm_rot8",  32'h00000000, 12'h4FF, 1'b1, 1'b0, 1'b0, 32'hFF000000, 1'b1, 3};
        tv[1] = '{"asr1",      32'h80000001, 12'h0C0, 1'b0, 1'b0, 1'b0, 32'hC0000000, 1'b1, 2};
        tv[2] = '{"mem_neg",   32'h12345678, 12'h800, 1'b1, 1'b1, 1'b1, 32'hFFFFF800, 1'b1, 1};
        tv[3] = '{"ror0",      32'h12345678, 12'h060, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b1, 1};
        tv[4] = '{"lsr4",      32'h000000F8, 12'h220, 1'b0, 1'b0, 1'b0, 32'h0000000F, 1'b1, 2};
        tv[5] = '{"ror5",      32'h0000001F, 12'h2E0, 1'b0, 1'b0, 1'b0, 32'hF8000000, 1'b1, 3};
        tv[6] = '{"imm_rot2",  32'hDEADBEEF, 12'h103, 1'b1, 1'b0, 1'b0, 32'hC0000000, 1'b1, 2};
        tv[7] = '{"lsl2",      32'h40000000, 12'h100, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 2};
        tv[8] = '{"asr12",     32'h8000F000, 12'h640, 1'b0, 1'b0, 1'b1, 32'hFFF8000F, 1'b0, 4};
        tv[9] = '{"imm_rot0",  32'hFFFFFFFF, 12'h0AB, 1'b1, 1'b0, 1'b0, 32'h000000AB, 1'b0, 1};

        #12 rst_n = 1'b1;
        @(negedge clk);
        check("rst.val2", bus.val2, 32'd0);
        check("rst.carry", {31'd0, bus.carry_out}, 32'd0);
        check("rst.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.req_ready", {31'd0, bus.req_ready}, 32'd1);

        for (int i = 0; i < 10; i++) run_vec(tv[i]);

        // LSL #31 with the consumer stalling five cycles and a competing request pending
        @(negedge clk);
        drive_req(32'h00000003, 12'hF80, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.mem_en = 1'b1;
        lat = 1;
        rr_seen = 1'b0;
        while (!bus.rsp_valid && lat < 64) begin
            if (bus.req_ready) rr_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check("stall.lat", lat, 9);
        check("stall.req_ready_shift", {31'd0, rr_seen}, 32'd0);
        check("stall.carry", {31'd0, bus.carry_out}, {31'd0, exp_c(1'b1)});
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("stall.rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("stall.val2", bus.val2, 32'h80000000);
            check("stall.req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("stall.release_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        check("stall.release_busy", {31'd0, busy}, 32'd0);
        check("stall.release_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // Flush two shift steps into an LSL #31 of 3
        @(negedge clk);
        drive_req(32'h00000003, 12'hF80, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        scramble();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("flush.busy", {31'd0, busy}, 32'd0);
        check("flush.req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("flush.val2_kept", bus.val2, 32'h00000300);
        @(negedge clk);
        flush = 1'b1;
        drive_req(32'h00000003, 12'hF80, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        scramble();
        check("flush.beats_accept", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("flush.no_rsp", {31'd0, seen}, 32'd0);

        // Asynchronous reset in the middle of a shift
        @(negedge clk);
        drive_req(32'h00000003, 12'hF80, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        scramble();
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst.val2", bus.val2, 32'd0);
        check("arst.busy", {31'd0, busy}, 32'd0);
        check("arst.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("arst.carry", {31'd0, bus.carry_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("arst.no_rsp", {31'd0, seen}, 32'd0);
        check("arst.req_ready", {31'd0, bus.req_ready}, 32'd1);
        run_vec(tv[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
